// File: rtl/packet_buffer_pkg.sv
// Shared types and helpers for the packet buffer read arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE waits for a lane, STREAM drains one packet)
//   lane_idx_t  : lane index type for the default four-lane configuration
//   cdiv        : ceiling division
//   max_beats   : beats needed to carry a maximum-length packet
package packet_buffer_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } arb_state_t;

  localparam int unsigned DEFAULT_NUM_LANES = 4;

  typedef logic [$clog2(DEFAULT_NUM_LANES)-1:0] lane_idx_t;

  function automatic int unsigned cdiv(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned max_beats(input int unsigned pkt_bytes,
                                            input int unsigned axi_width);
    return cdiv(pkt_bytes, axi_width / 8);
  endfunction

endpackage

// File: rtl/packet_buffer_read_arbiter_if.sv
// Merged output stream of the packet buffer read arbiter.
//   m_data_o / m_valid_o / m_last_o / m_lane_o : beat towards downstream
//   m_ready_i      : downstream ready
//   err_oversize_o : one-cycle pulse when a packet exceeds the maximum length
// master = arbiter side, slave = downstream consumer side.
interface packet_buffer_read_arbiter_if #(
  parameter int unsigned AXI_WIDTH             = 64,
  parameter int unsigned LANE_SELECT_IDX_WIDTH = 2
) ();

  logic [AXI_WIDTH-1:0]             m_data_o;
  logic                             m_valid_o;
  logic                             m_last_o;
  logic [LANE_SELECT_IDX_WIDTH-1:0] m_lane_o;
  logic                             m_ready_i;
  logic                             err_oversize_o;

  modport master (
    output m_data_o, m_valid_o, m_last_o, m_lane_o, err_oversize_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o, m_valid_o, m_last_o, m_lane_o, err_oversize_o,
    output m_ready_i
  );

endinterface

// File: rtl/packet_buffer_skid_buffer.sv
// Two-entry skid buffer with a registered output stage.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_data_i/in_valid_i/in_ready_o    : upstream handshake
//   out_data_o/out_valid_o/out_ready_i : downstream handshake
// A beat accepted on the input appears on the output the next cycle when the
// output slot is free or draining; in_ready_o depends only on local state.
module packet_buffer_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_q, skid_q;
  logic             out_vq, skid_vq;
  logic             in_fire, out_free;

  assign in_ready_o  = ~skid_vq;
  assign in_fire     = in_valid_i & ~skid_vq;
  assign out_free    = ~out_vq | out_ready_i;
  assign out_data_o  = out_q;
  assign out_valid_o = out_vq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q   <= '0;
      skid_q  <= '0;
      out_vq  <= 1'b0;
      skid_vq <= 1'b0;
    end else if (out_free) begin
      // Skid entry is older than anything on the input, so it refills first;
      // while it is occupied in_ready_o is low and no new beat can arrive.
      if (skid_vq) begin
        out_q   <= skid_q;
        out_vq  <= 1'b1;
        skid_vq <= 1'b0;
      end else if (in_fire) begin
        out_q  <= in_data_i;
        out_vq <= 1'b1;
      end else begin
        out_vq <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q  <= in_data_i;
      skid_vq <= 1'b1;
    end
  end

endmodule

// File: rtl/packet_buffer_read_arbiter.sv
// Round-robin, packet-granular read arbiter draining NUM_LANES lane FIFOs into
// one stream.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   lane_data_i    : lane FIFO read data
//   lane_valid_i   : lane FIFO non-empty
//   lane_last_i    : final beat of a packet on that lane
//   lane_ready_o   : pop strobe towards the granted lane
//   m_if (master)  : merged output stream plus oversize error pulse
// A lane keeps the grant until its last beat is accepted; each packet costs one
// IDLE cycle, in which the next grant is picked starting at rr_ptr.
module packet_buffer_read_arbiter
  import packet_buffer_pkg::*;
#(
  parameter int unsigned NUM_LANES             = 4,
  parameter int unsigned AXI_WIDTH             = 64,
  parameter int unsigned MAX_PACKET_LENGTH     = 1536,
  parameter int unsigned LANE_SELECT_IDX_WIDTH = $clog2(NUM_LANES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AXI_WIDTH-1:0] lane_data_i [NUM_LANES],
  input  logic [NUM_LANES-1:0] lane_valid_i,
  input  logic [NUM_LANES-1:0] lane_last_i,
  output logic [NUM_LANES-1:0] lane_ready_o,
  packet_buffer_read_arbiter_if.master m_if
);

  localparam int unsigned MAX_BEATS = max_beats(MAX_PACKET_LENGTH, AXI_WIDTH);
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(MAX_BEATS - 1);
  localparam int unsigned SKID_W    = LANE_SELECT_IDX_WIDTH + 1 + AXI_WIDTH;

  typedef logic [LANE_SELECT_IDX_WIDTH-1:0] idx_t;

  arb_state_t       state_q, state_d;
  idx_t             grant_q, rr_ptr_q, pick_idx, grant_next;
  logic             pick_found;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             err_q;
  logic             skid_in_valid, skid_in_ready;
  logic             beat_acc, last_acc;
  logic [SKID_W-1:0] skid_in, skid_out;

  assign beat_acc   = (state_q == STREAM) & lane_valid_i[grant_q] & skid_in_ready;
  assign last_acc   = beat_acc & lane_last_i[grant_q];
  assign grant_next = (grant_q == idx_t'(NUM_LANES - 1)) ? '0 : grant_q + 1'b1;
  assign skid_in    = {grant_q, lane_last_i[grant_q], lane_data_i[grant_q]};

  // First valid lane at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      idx_t cand;
      cand = idx_t'((32'(rr_ptr_q) + i) % NUM_LANES);
      if (!pick_found && lane_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    lane_ready_o  = '0;
    skid_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) state_d = STREAM;
      end
      STREAM: begin
        lane_ready_o[grant_q] = skid_in_ready;
        skid_in_valid         = lane_valid_i[grant_q];
        if (last_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (state_q == IDLE && pick_found) begin
        grant_q    <= pick_idx;
        beat_cnt_q <= '0;
      end
      if (beat_acc) begin
        if (beat_cnt_q != CNT_MAX) beat_cnt_q <= beat_cnt_q + 1'b1;
        // Only the beat that reaches the limit flags; the saturated counter
        // keeps later beats of the same packet from pulsing again.
        if (!lane_last_i[grant_q] && beat_cnt_q == CNT_WARN) err_q <= 1'b1;
      end
      if (last_acc) rr_ptr_q <= grant_next;
    end
  end

  packet_buffer_skid_buffer #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_data_i  (skid_in),
    .in_valid_i (skid_in_valid),
    .in_ready_o (skid_in_ready),
    .out_data_o (skid_out),
    .out_valid_o(m_if.m_valid_o),
    .out_ready_i(m_if.m_ready_i)
  );

  assign m_if.m_data_o       = skid_out[AXI_WIDTH-1:0];
  assign m_if.m_last_o       = skid_out[AXI_WIDTH];
  assign m_if.m_lane_o       = skid_out[SKID_W-1 -: LANE_SELECT_IDX_WIDTH];
  assign m_if.err_oversize_o = err_q;

endmodule

// File: doc/packet_buffer_read_arbiter.md
PACKET_BUFFER_READ_ARBITER -- requirements
Module: packet_buffer_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of lane FIFOs drained.
REQ-002 SHALL have parameter AXI_WIDTH, default 64: data bits per beat.
REQ-003 SHALL have parameter MAX_PACKET_LENGTH, default 1536: maximum packet size in bytes.
REQ-004 SHALL have parameter LANE_SELECT_IDX_WIDTH, default $clog2(NUM_LANES): lane index width.
REQ-005 SHALL have port clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port lane_data_i [NUM_LANES], input, AXI_WIDTH: lane FIFO read data.
REQ-008 SHALL have port lane_valid_i [NUM_LANES], input, 1: lane FIFO non-empty.
REQ-009 SHALL have port lane_last_i [NUM_LANES], input, 1: final beat of a packet.
REQ-010 SHALL have port lane_ready_o [NUM_LANES], input-side pop, output, 1; lane_valid_i && lane_ready_o form the drain handshake also fed to the write controller.
REQ-011 SHALL have ports m_data_o (AXI_WIDTH), m_valid_o (1), m_last_o (1), m_lane_o (LANE_SELECT_IDX_WIDTH), all outputs: merged stream.
REQ-012 SHALL have port m_ready_i, input, 1: downstream ready.
REQ-013 SHALL have port err_oversize_o, output, 1: one-cycle pulse on an over-length packet.

Function
REQ-014 SHALL implement FSM states IDLE and STREAM.
REQ-015 In IDLE, all lane_ready_o SHALL be 0; if any lane_valid_i is 1, the arbiter SHALL latch grant = first valid lane at or after rr_ptr (wrapping modulo NUM_LANES) and enter STREAM next cycle.
REQ-016 In STREAM, only lane_ready_o[grant] SHALL equal the skid buffer's input ready; all others SHALL be 0.
REQ-017 The grant SHALL NOT change until a beat with lane_last_i[grant]=1 is accepted; lane_valid_i gaps mid-packet SHALL stall the arbiter on that lane.
REQ-018 On acceptance of the last beat, the FSM SHALL return to IDLE and rr_ptr SHALL become grant+1 (wrapping NUM_LANES-1 -> 0).
REQ-019 Per-packet cost SHALL be exactly one IDLE bubble cycle; within a packet throughput SHALL be one beat per cycle when m_ready_i=1.
REQ-020 Accepted beats SHALL pass through a two-entry skid buffer: data, last and lane index appear on m_* exactly one cycle after acceptance when not stalled.
REQ-021 m_* SHALL hold stable while m_valid_o=1 and m_ready_i=0; no beat SHALL be dropped or duplicated.
REQ-022 Beat counter width SHALL be $clog2(MAX_BEATS)+1, MAX_BEATS = ceil(MAX_PACKET_LENGTH/(AXI_WIDTH/8)); it SHALL clear on IDLE->STREAM and increment per accepted beat.
REQ-023 When an accepted non-last beat brings the count to MAX_BEATS, err_oversize_o SHALL pulse once for that packet; the counter SHALL saturate and streaming SHALL continue until last.
REQ-024 A lane asserting valid while another lane streams SHALL wait; with all lanes valid continuously, service order SHALL be 0,1,...,NUM_LANES-1,0.

Reset
REQ-025 On rst_ni=0, asynchronously: FSM=IDLE, rr_ptr=0, grant=0, beat counter=0, skid buffer empty.
REQ-026 During and after reset: m_valid_o=0, m_last_o=0, m_data_o=0, m_lane_o=0, err_oversize_o=0, all lane_ready_o=0.
REQ-027 Reset mid-packet SHALL discard skid contents; the partial packet is not resumed.

Structure
REQ-028 MAX_BEATS computation (via cdiv) and the lane index type SHALL be in packet_buffer_pkg.
REQ-029 The skid buffer SHALL be a sub-module packet_buffer_skid_buffer (parameterised width, same clock/reset).

Verification
REQ-030 Single 3-beat packet on lane 2, m_ready_i=1 -> lane 2 popped cycles 2-4, m_valid_o cycles 3-5, m_lane_o=2, m_last_o on 3rd beat.
REQ-031 All 4 lanes hold 2-beat packets -> output order lanes 0,1,2,3, one bubble between packets, rr_ptr wraps to 0.
REQ-032 m_ready_i toggled 1/0 every cycle over 8 beats -> all 8 beats emitted in order, none lost/duplicated, m_* stable during stalls.
REQ-033 AXI_WIDTH=64, MAX_PACKET_LENGTH=64, 10-beat packet -> err_oversize_o single pulse on acceptance of beat 8, all 10 beats delivered.
REQ-034 rst_ni asserted after beat 2 of a 5-beat packet -> m_valid_o=0 and lane_ready_o=0 immediately; after release the next packet is from lane 0 if valid.
